// File: rtl/prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch front end.
package prefetch_unit_pkg;

    // Ring pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // What happens to a ROM response in the cycle it arrives.
    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_FILL,
        RSP_DROP
    } rsp_kind_e;

endpackage

// File: rtl/prefetch_unit_ring.sv
// DEPTH-entry ring of {pc, data, filled}. An entry is allocated when its fetch
// issues, filled when the ROM answers, and popped when decode takes it.
module prefetch_unit_ring
    import prefetch_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [XLEN-1:0]  fill_data,
    input  logic             pop,
    output logic [PTR_W-1:0] occupancy,
    output logic [PTR_W-1:0] pending,
    output logic             head_valid,
    output logic [XLEN-1:0]  head_pc,
    output logic [XLEN-1:0]  head_data
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [DEPTH-1:0] filled;

    assign rd_idx   = rd_ptr[IDX_W-1:0];
    assign wr_idx   = wr_ptr[IDX_W-1:0];
    assign fill_idx = fill_ptr[IDX_W-1:0];

    // Entries allocated or filled but not yet popped; pending = issued, not yet returned.
    assign occupancy  = wr_ptr - rd_ptr;
    assign pending    = wr_ptr - fill_ptr;
    assign head_valid = filled[rd_idx] && (rd_ptr != wr_ptr);
    assign head_pc    = pc_mem[rd_idx];
    assign head_data  = data_mem[rd_idx];

    // Payload storage needs no reset: the filled bits and pointers qualify it.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem[wr_idx] <= alloc_pc;
        end
        if (fill) begin
            data_mem[fill_idx] <= fill_data;
        end
    end

    // Pointer and filled-bit bookkeeping; flush empties the ring in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            filled   <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            filled   <= '0;
        end else begin
            if (alloc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fill) begin
                filled[fill_idx] <= 1'b1;
                fill_ptr         <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                filled[rd_idx] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction fetch front end: streams sequential PCs to the ROM, buffers the
// returned words in a ring and hands (instr, instr_pc) to decode. A redirect
// flushes the ring and counts every still-outstanding response for discard.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            rom_req,
    output logic [XLEN-1:0] rom_addr,
    input  logic            rom_valid,
    input  logic [XLEN-1:0] rom_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] fetch_pc
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0] drop_cnt;
    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] pending;
    logic [PTR_W:0]   committed;
    logic             credit_ok;
    logic             head_valid;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_data;
    logic             accept;
    rsp_kind_e        rsp_kind;

    // Ring slots in use plus stale responses still owed by the ROM bound new issues,
    // so a response always has somewhere to land or a drop slot waiting for it.
    assign committed = {1'b0, occupancy} + {1'b0, drop_cnt};
    assign credit_ok = committed < (PTR_W+1)'(DEPTH);

    assign rom_req  = rst_n && !pc_src && credit_ok;
    assign rom_addr = fetch_pc;

    assign instr_valid = head_valid && !pc_src;
    assign instr       = instr_valid ? head_data : '0;
    assign instr_pc    = instr_valid ? head_pc   : '0;
    assign accept      = instr_valid && instr_ready;

    // Stale responses (owed from before a redirect, or arriving during one) are discarded.
    always_comb begin
        rsp_kind = RSP_IDLE;
        if (rom_valid) begin
            if (pc_src || (drop_cnt != '0)) begin
                rsp_kind = RSP_DROP;
            end else begin
                rsp_kind = RSP_FILL;
            end
        end
    end

    // Fetch address and stale-response counter; a redirect re-targets and converts
    // every request still in the ROM pipe into a pending drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (pc_src) begin
            fetch_pc <= branch_target;
            drop_cnt <= drop_cnt + pending - PTR_W'(rom_valid);
        end else begin
            if (rom_req) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end
            if (rsp_kind == RSP_DROP) begin
                drop_cnt <= drop_cnt - PTR_W'(1);
            end
        end
    end

    prefetch_unit_ring #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (pc_src),
        .alloc      (rom_req),
        .alloc_pc   (fetch_pc),
        .fill       (rsp_kind == RSP_FILL),
        .fill_data  (rom_data),
        .pop        (accept),
        .occupancy  (occupancy),
        .pending    (pending),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_data  (head_data)
    );

    // A response with nothing outstanding means the ROM and this unit disagree about the stream.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        rom_valid |-> ((drop_cnt != '0) || (pending != '0)));

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: an in-order ROM with configurable latency, random
// decode back-pressure and redirects, checked against a transaction-level model.
module tb_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC_W = 32'hFFFF_FFFE;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_valid;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;

    logic        rom_req_w;
    logic [31:0] rom_addr_w;
    logic        rom_valid_w;
    logic [31:0] rom_data_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic [31:0] fetch_pc_w;

    prefetch_unit #(.XLEN(32), .PC_STEP(1), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .fetch_pc(fetch_pc)
    );

    prefetch_unit #(.XLEN(32), .PC_STEP(1), .RESET_PC(RST_PC_W), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(rst_n), .pc_src(1'b0), .branch_target(32'h0),
        .rom_req(rom_req_w), .rom_addr(rom_addr_w), .rom_valid(rom_valid_w), .rom_data(rom_data_w),
        .instr_valid(instr_valid_w), .instr_ready(1'b1), .instr(instr_w),
        .instr_pc(instr_pc_w), .fetch_pc(fetch_pc_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } rom_txn_t;

    rom_txn_t    rom_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          buffered = 0;
    int          delivered = 0;
    logic [31:0] exp_issue;
    logic [31:0] exp_pc;
    int          lat_lo, lat_hi, ready_pct, redir_pct;
    bit          force_redir = 0;
    logic [31:0] force_tgt;
    bit          w_pend;
    logic [31:0] w_pend_addr;
    logic [31:0] w_exp_issue;
    logic [31:0] w_exp_pc;
    int          w_cyc;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_knobs(input int lo, input int hi, input int rdy, input int rdr);
        lat_lo = lo; lat_hi = hi; ready_pct = rdy; redir_pct = rdr;
    endtask

    // Called just after a rising edge; leaves time just after the release edge.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        pc_src = 1'b0; rom_valid = 1'b0; instr_ready = 1'b0; rom_valid_w = 1'b0;
        rom_q.delete();
        buffered = 0; epoch++;
        exp_issue = 32'h0; exp_pc = 32'h0;
        w_pend = 1'b0; w_exp_issue = RST_PC_W; w_exp_pc = RST_PC_W; w_cyc = 0;
        #2;
        check_eq("rst_rom_req", 32'(rom_req), 32'h0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_fetch_pc", fetch_pc, 32'h0);
        check_eq("rst_fetch_pc_w", fetch_pc_w, RST_PC_W);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        bit       exp_req;
        bit       exp_valid;
        rom_txn_t t;
        if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
            rom_valid = 1'b1;
            rom_data  = rom_fn(rom_q[0].addr);
        end else begin
            rom_valid = 1'b0;
            rom_data  = $urandom;
        end
        pc_src        = force_redir || ($urandom_range(99) < redir_pct);
        branch_target = force_redir ? force_tgt : $urandom;
        force_redir   = 1'b0;
        instr_ready   = $urandom_range(99) < ready_pct;
        rom_valid_w   = w_pend;
        rom_data_w    = rom_fn(w_pend_addr);

        @(negedge clk);
        exp_req   = !pc_src && ((rom_q.size() + buffered) < DEPTH);
        exp_valid = !pc_src && (buffered > 0);
        check_eq("rom_req", 32'(rom_req), 32'(exp_req));
        check_eq("fetch_pc", fetch_pc, exp_issue);
        if (rom_req) check_eq("rom_addr", rom_addr, exp_issue);
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instr", instr, rom_fn(exp_pc));
        end else begin
            check_eq("idle_instr_pc", instr_pc, 32'h0);
            check_eq("idle_instr", instr, 32'h0);
        end

        check_eq("w_req", 32'(rom_req_w), 32'h1);
        if (rom_req_w) begin
            check_eq("w_addr", rom_addr_w, w_exp_issue);
            w_exp_issue = w_exp_issue + 32'h1;
        end
        check_eq("w_valid", 32'(instr_valid_w), 32'(w_cyc >= 2));
        if (instr_valid_w) begin
            check_eq("w_instr_pc", instr_pc_w, w_exp_pc);
            check_eq("w_instr", instr_w, rom_fn(w_exp_pc));
            w_exp_pc = w_exp_pc + 32'h1;
        end
        w_pend      = rom_req_w;
        w_pend_addr = rom_addr_w;

        if (rom_valid) begin
            t = rom_q.pop_front();
            if (!pc_src && t.epoch == epoch) buffered++;
        end
        if (exp_valid && instr_ready) begin
            buffered--;
            exp_pc = exp_pc + 32'h1;
            delivered++;
        end
        if (rom_req) begin
            t.addr  = rom_addr;
            t.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
            t.epoch = epoch;
            rom_q.push_back(t);
            exp_issue = exp_issue + 32'h1;
        end
        if (pc_src) begin
            epoch++;
            buffered  = 0;
            exp_issue = branch_target;
            exp_pc    = branch_target;
        end

        @(posedge clk);
        #1;
        cyc++;
        w_cyc++;
    endtask

    initial begin
        rst_n = 1'b1;
        pc_src = 1'b0; branch_target = '0; rom_valid = 1'b0; rom_data = '0;
        instr_ready = 1'b0; rom_valid_w = 1'b0; rom_data_w = '0;
        w_pend_addr = '0;
        set_knobs(1, 1, 100, 0);
        #1;

        // Steady stream at latency 1, decode always ready.
        do_reset(2);
        set_knobs(1, 1, 100, 0);
        repeat (16) step();

        // Decode stalled at latency 3: issue stops at DEPTH, then drains in order.
        do_reset(2);
        set_knobs(3, 3, 0, 0);
        repeat (10) step();
        ready_pct = 100;
        repeat (14) step();

        // Redirect with three fetches in flight.
        do_reset(2);
        set_knobs(3, 3, 100, 0);
        repeat (3) step();
        force_redir = 1'b1; force_tgt = 32'h100;
        step();
        repeat (14) step();

        // Redirect colliding with a response and an accept, then back-to-back redirects.
        do_reset(2);
        set_knobs(1, 1, 100, 0);
        repeat (5) step();
        force_redir = 1'b1; force_tgt = 32'h200;
        step();
        force_redir = 1'b1; force_tgt = 32'h300;
        step();
        repeat (10) step();
        set_knobs(3, 3, 100, 0);
        repeat (6) step();
        force_redir = 1'b1; force_tgt = 32'h400;
        step();
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFF;
        step();
        repeat (12) step();

        // Random latency, back-pressure and redirects, with resets mid-stream.
        for (int seg = 0; seg < 6; seg++) begin
            set_knobs(1, 5, 40 + 10 * seg, (seg % 3) * 4);
            repeat (350) step();
            do_reset(1 + seg % 2);
        end
        set_knobs(1, 5, 80, 3);
        repeat (200) step();

        check_eq("progress", 32'(delivered > 500), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
